// File: rtl/athos_xif_offload_master_if.sv
// Signal bundle between the XIF offload master and its partners (command source,
// ATHOS coprocessor, response sink). Names keep the master's port naming.
interface athos_xif_offload_master_if #(
    parameter int ID_W = 4
) ();
    // Command channel
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic [31:0]     cmd_instr_i;
    logic [31:0]     cmd_rs1_i;
    logic [31:0]     cmd_rs2_i;
    // Issue channel
    logic            issue_valid_o;
    logic            issue_ready_i;
    logic [31:0]     issue_instr_o;
    logic [31:0]     issue_rs0_o;
    logic [31:0]     issue_rs1_o;
    logic [1:0]      issue_rs_valid_o;
    logic [ID_W-1:0] issue_id_o;
    logic            issue_accept_i;
    logic            issue_writeback_i;
    logic            issue_dualwrite_i;
    // Commit channel
    logic            commit_valid_o;
    logic [ID_W-1:0] commit_id_o;
    logic            commit_kill_o;
    // Result channel
    logic            result_valid_i;
    logic            result_ready_o;
    logic [ID_W-1:0] result_id_i;
    logic [4:0]      result_rd_i;
    logic [31:0]     result_data_i;
    // Response channel
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [63:0]     rsp_data_o;
    logic [4:0]      rsp_rd_o;
    logic [1:0]      rsp_status_o;

    modport master (
        input  cmd_valid_i, cmd_instr_i, cmd_rs1_i, cmd_rs2_i,
        output cmd_ready_o,
        output issue_valid_o, issue_instr_o, issue_rs0_o, issue_rs1_o, issue_rs_valid_o, issue_id_o,
        input  issue_ready_i, issue_accept_i, issue_writeback_i, issue_dualwrite_i,
        output commit_valid_o, commit_id_o, commit_kill_o,
        input  result_valid_i, result_id_i, result_rd_i, result_data_i,
        output result_ready_o,
        output rsp_valid_o, rsp_data_o, rsp_rd_o, rsp_status_o,
        input  rsp_ready_i
    );

    modport slave (
        output cmd_valid_i, cmd_instr_i, cmd_rs1_i, cmd_rs2_i,
        input  cmd_ready_o,
        input  issue_valid_o, issue_instr_o, issue_rs0_o, issue_rs1_o, issue_rs_valid_o, issue_id_o,
        output issue_ready_i, issue_accept_i, issue_writeback_i, issue_dualwrite_i,
        input  commit_valid_o, commit_id_o, commit_kill_o,
        output result_valid_i, result_id_i, result_rd_i, result_data_i,
        input  result_ready_o,
        input  rsp_valid_o, rsp_data_o, rsp_rd_o, rsp_status_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/athos_xif_offload_master.sv
// CPU-side XIF initiator: takes one command, runs issue/commit/result against ATHOS
// and returns a single response. One instruction in flight at a time.
module athos_xif_offload_master #(
    parameter int ID_W        = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input logic                        clk_i,
    input logic                        rst_ni,
    athos_xif_offload_master_if.master xif
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_COMMIT,
        S_WAIT_RES,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_REJECTED = 2'd1,
        ST_TIMEOUT  = 2'd2,
        ST_NO_WB    = 2'd3
    } status_e;

    localparam int              CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit              TMO_EN   = (TIMEOUT_CYC > 0);

    state_e          state_q, state_d;
    status_e         status_q, status_d;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic [ID_W-1:0] id_q;
    logic [31:0]     instr_q, rs1_q, rs2_q;
    logic [31:0]     data0_q, data1_q;
    logic [4:0]      rd_q;
    logic            dual_q, wb_q, beat_cnt_q;
    logic            capture, issue_hs, beat, last_beat, tmo_hit;

    // ATHOS always returns result id 0, so the returned id is deliberately not checked.
    logic unused_result_id;
    assign unused_result_id = ^xif.result_id_i;

    assign tmo_hit   = TMO_EN && (tmo_cnt_q == TMO_LAST);
    assign last_beat = !dual_q || beat_cnt_q;

    // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        capture  = 1'b0;
        issue_hs = 1'b0;
        beat     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (xif.cmd_valid_i) begin
                    capture = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (xif.issue_ready_i) begin
                    issue_hs = 1'b1;
                    if (!xif.issue_accept_i) begin
                        status_d = ST_REJECTED;
                        state_d  = S_RESP;
                    end else begin
                        status_d = xif.issue_writeback_i ? ST_OK : ST_NO_WB;
                        state_d  = S_COMMIT;
                    end
                end else if (tmo_hit) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_RESP;
                end
            end
            S_COMMIT: begin
                state_d = wb_q ? S_WAIT_RES : S_RESP;
            end
            S_WAIT_RES: begin
                if (xif.result_valid_i) begin
                    beat = 1'b1;
                    if (last_beat) state_d = S_RESP;
                end else if (tmo_hit) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (xif.rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            status_q  <= ST_OK;
            tmo_cnt_q <= '0;
            id_q      <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            // A received beat counts as progress and restarts the wait window.
            if (state_d != state_q || beat) begin
                tmo_cnt_q <= '0;
            end else if (state_q == S_ISSUE || state_q == S_WAIT_RES) begin
                tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end
            if (state_q == S_COMMIT) id_q <= id_q + ID_W'(1);
        end
    end

    // NOTE: payload registers are reset too, because they drive outputs that must read 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
            rd_q       <= '0;
            dual_q     <= 1'b0;
            wb_q       <= 1'b0;
            beat_cnt_q <= 1'b0;
        end else begin
            if (capture) begin
                instr_q    <= xif.cmd_instr_i;
                rs1_q      <= xif.cmd_rs1_i;
                rs2_q      <= xif.cmd_rs2_i;
                data0_q    <= '0;
                data1_q    <= '0;
                rd_q       <= '0;
                beat_cnt_q <= 1'b0;
            end
            if (issue_hs) begin
                dual_q <= xif.issue_dualwrite_i;
                wb_q   <= xif.issue_writeback_i;
            end
            if (beat) begin
                if (!beat_cnt_q) begin
                    data0_q <= xif.result_data_i;
                    rd_q    <= xif.result_rd_i;
                end else begin
                    data1_q <= xif.result_data_i;
                end
                beat_cnt_q <= 1'b1;
            end
        end
    end

    assign xif.cmd_ready_o      = (state_q == S_IDLE);
    assign xif.issue_valid_o    = (state_q == S_ISSUE);
    assign xif.issue_instr_o    = instr_q;
    assign xif.issue_rs0_o      = rs1_q;
    assign xif.issue_rs1_o      = rs2_q;
    assign xif.issue_rs_valid_o = {2{state_q == S_ISSUE}};
    assign xif.issue_id_o       = id_q;
    assign xif.commit_valid_o   = (state_q == S_COMMIT);
    assign xif.commit_id_o      = id_q;
    // A timed-out issue never handshook, so no commit transaction exists to carry a kill.
    assign xif.commit_kill_o    = 1'b0;
    assign xif.result_ready_o   = (state_q == S_WAIT_RES);
    assign xif.rsp_valid_o      = (state_q == S_RESP);
    assign xif.rsp_data_o       = {data1_q, data0_q};
    assign xif.rsp_rd_o         = rd_q;
    assign xif.rsp_status_o     = status_q;
endmodule

// File: tb/tb_athos_xif_offload_master.sv
// Scoreboard bench for athos_xif_offload_master: directed commands push expected
// responses/commit ids; independent monitors pop and compare on each DUT handshake.
module tb_athos_xif_offload_master;
    localparam int ID_W = 4;
    localparam int TMO  = 8;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic [1:0]  status;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    athos_xif_offload_master_if #(.ID_W(ID_W)) xif ();

    athos_xif_offload_master #(
        .ID_W       (ID_W),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .xif   (xif.master)
    );

    rsp_t            rsp_q[$];
    logic [ID_W-1:0] commit_q[$];
    logic [ID_W-1:0] id_model = '0;
    rsp_t            mon_rsp;
    logic [ID_W-1:0] mon_id;
    int              checks = 0;
    int              failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=no event within cycle budget required=event", name);
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rst_n && xif.rsp_valid_o && xif.rsp_ready_i) begin
            if (rsp_q.size() == 0) begin
                bound_fail("rsp_unexpected");
            end else begin
                mon_rsp = rsp_q.pop_front();
                check("rsp_data", xif.rsp_data_o, mon_rsp.data);
                check("rsp_rd", 64'(xif.rsp_rd_o), 64'(mon_rsp.rd));
                check("rsp_status", 64'(xif.rsp_status_o), 64'(mon_rsp.status));
            end
        end
    end

    // Commit monitor
    always @(negedge clk) begin
        if (rst_n && xif.commit_valid_o) begin
            if (commit_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL commit_unexpected: actual=commit id 0x%0h required=no commit", xif.commit_id_o);
            end else begin
                mon_id = commit_q.pop_front();
                check("commit_id", 64'(xif.commit_id_o), 64'(mon_id));
                check("commit_kill", 64'(xif.commit_kill_o), 64'd0);
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(xif.cmd_ready_o), 64'd1);
        check({tag, "_issue_valid"}, 64'(xif.issue_valid_o), 64'd0);
        check({tag, "_issue_rs_valid"}, 64'(xif.issue_rs_valid_o), 64'd0);
        check({tag, "_issue_id"}, 64'(xif.issue_id_o), 64'd0);
        check({tag, "_issue_instr"}, 64'(xif.issue_instr_o), 64'd0);
        check({tag, "_commit_valid"}, 64'(xif.commit_valid_o), 64'd0);
        check({tag, "_result_ready"}, 64'(xif.result_ready_o), 64'd0);
        check({tag, "_rsp_valid"}, 64'(xif.rsp_valid_o), 64'd0);
        check({tag, "_rsp_data"}, xif.rsp_data_o, 64'd0);
        check({tag, "_rsp_status"}, 64'(xif.rsp_status_o), 64'd0);
    endtask

    task automatic run_cmd(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                           input logic [31:0] rs2, input bit accept, input bit wb, input bit dual,
                           input bit never_ready, input bit abort, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [4:0] rd, input int stall);
        rsp_t e;
        int   n;
        e.status = never_ready ? 2'd2 : (!accept ? 2'd1 : (!wb ? 2'd3 : 2'd0));
        e.data   = (e.status == 2'd0) ? {dual ? d1 : 32'h0, d0} : 64'h0;
        e.rd     = (e.status == 2'd0) ? rd : 5'd0;
        if (!abort) rsp_q.push_back(e);
        if (accept && !never_ready) commit_q.push_back(id_model);

        @(posedge clk); #1;
        xif.cmd_valid_i = 1'b1;
        xif.cmd_instr_i = instr;
        xif.cmd_rs1_i   = rs1;
        xif.cmd_rs2_i   = rs2;
        n = 0;
        @(negedge clk);
        while (!xif.cmd_ready_o && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) bound_fail({tag, "_cmd_ready_wait"});
        @(posedge clk); #1;
        xif.cmd_valid_i       = 1'b0;
        xif.issue_ready_i     = !never_ready;
        xif.issue_accept_i    = accept;
        xif.issue_writeback_i = wb;
        xif.issue_dualwrite_i = dual;

        @(negedge clk);
        check({tag, "_issue_valid"}, 64'(xif.issue_valid_o), 64'd1);
        check({tag, "_issue_instr"}, 64'(xif.issue_instr_o), 64'(instr));
        check({tag, "_issue_rs0"}, 64'(xif.issue_rs0_o), 64'(rs1));
        check({tag, "_issue_rs1"}, 64'(xif.issue_rs1_o), 64'(rs2));
        check({tag, "_issue_rs_valid"}, 64'(xif.issue_rs_valid_o), 64'd3);
        check({tag, "_issue_id"}, 64'(xif.issue_id_o), 64'(id_model));
        if (accept && !never_ready) id_model = id_model + 1'b1;

        if (never_ready) begin
            n = 1;
            while (n < 40) begin
                @(negedge clk);
                if (!xif.issue_valid_o) break;
                n++;
            end
            check({tag, "_issue_valid_cycles"}, 64'(n), 64'(TMO));
        end else begin
            @(posedge clk); #1;
            xif.issue_ready_i = 1'b0;
            if (accept && wb) begin
                // Junk beat while not yet in WAIT_RES must be ignored.
                xif.result_valid_i = 1'b1;
                xif.result_data_i  = 32'hDEAD_BEEF;
                xif.result_rd_i    = 5'd31;
                n = 0;
                @(negedge clk);
                while (!xif.result_ready_o && n < 20) begin @(negedge clk); n++; end
                if (n >= 20) bound_fail({tag, "_result_ready_wait"});
                if (abort) begin
                    rst_n = 1'b0;
                    #1;
                    check_idle_outputs({tag, "_midreset"});
                    xif.result_valid_i = 1'b0;
                    id_model = '0;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    return;
                end
                xif.result_data_i = d0;
                xif.result_rd_i   = rd;
                @(posedge clk); #1;
                if (dual) begin
                    xif.result_data_i = d1;
                    xif.result_rd_i   = rd + 5'd1;
                    @(posedge clk); #1;
                end
                xif.result_valid_i = 1'b0;
            end
        end

        n = 0;
        @(negedge clk);
        while (!xif.rsp_valid_o && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) bound_fail({tag, "_rsp_valid_wait"});
        repeat (stall) begin
            check({tag, "_stall_rsp_data"}, xif.rsp_data_o, e.data);
            check({tag, "_stall_rsp_status"}, 64'(xif.rsp_status_o), 64'(e.status));
            check({tag, "_stall_cmd_ready"}, 64'(xif.cmd_ready_o), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        xif.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        xif.rsp_ready_i = 1'b0;
        @(negedge clk);
        check({tag, "_cmd_ready_after"}, 64'(xif.cmd_ready_o), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        xif.cmd_valid_i       = 1'b0;
        xif.cmd_instr_i       = '0;
        xif.cmd_rs1_i         = '0;
        xif.cmd_rs2_i         = '0;
        xif.issue_ready_i     = 1'b0;
        xif.issue_accept_i    = 1'b0;
        xif.issue_writeback_i = 1'b0;
        xif.issue_dualwrite_i = 1'b0;
        xif.result_valid_i    = 1'b0;
        xif.result_id_i       = '0;
        xif.result_rd_i       = '0;
        xif.result_data_i     = '0;
        xif.rsp_ready_i       = 1'b0;

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        //       tag        instr          rs1           rs2           acc wb dual nrdy abort d0            d1            rd     stall
        run_cmd("montg",   32'h0200_000B, 32'h0000_1234, 32'h0000_5678, 1, 1, 0, 0, 0, 32'h0000_CAFE, 32'h0,        5'd7,  0);
        run_cmd("load64",  32'h0000_302B, 32'h0000_0100, 32'h0,        1, 1, 1, 0, 0, 32'h1111_1111, 32'h2222_2222, 5'd3,  1);
        run_cmd("unknown", 32'hFFFF_FFFF, 32'h0000_00AA, 32'h0000_00BB, 0, 0, 0, 0, 0, 32'h0,        32'h0,        5'd0,  0);
        run_cmd("timeout", 32'h0200_000B, 32'h0000_0001, 32'h0000_0002, 1, 1, 0, 1, 0, 32'h0,        32'h0,        5'd0,  0);
        run_cmd("no_wb",   32'h0400_000B, 32'h0000_0003, 32'h0000_0004, 1, 0, 0, 0, 0, 32'h0,        32'h0,        5'd0,  0);
        for (int i = 0; i < 17; i++) begin
            run_cmd("wrap", 32'h0200_000B, 32'(i), 32'(i * 3), 1, 1, 0, 0, 0,
                    32'hA000_0000 + 32'(i), 32'h0, 5'(i), (i == 5) ? 3 : 0);
        end
        run_cmd("abort",   32'h0200_000B, 32'h0000_0055, 32'h0000_0066, 1, 1, 0, 0, 1, 32'h0,        32'h0,        5'd0,  0);
        run_cmd("post_rst", 32'h0200_000B, 32'h0000_0077, 32'h0000_0088, 1, 1, 0, 0, 0, 32'h0000_BEEF, 32'h0,       5'd9,  0);

        repeat (3) @(negedge clk);
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        check("commit_queue_drained", 64'(commit_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
